ram8x72_req_ctrl: RTL and testbench

- Request-side controller that sits directly upstream of a pair of 4x72 DFF RAM banks. Together they form the 8x72 RAM.
- Accepts valid/ready read/write requests with a 3-bit word address. Bit 2 selects the bank; bits 1:0 select the word.
- Drives the banks' active-low enable/write strobes and collects their 1-cycle-latency read data into a response FIFO with backpressure.
- After every reset it zero-fills all 8 words before accepting traffic, because the banks have no reset.

---
 rtl/ram8x72_req_ctrl_pkg.sv | 22 ++
 rtl/ram_rsp_fifo.sv | 85 ++++++++
 rtl/ram8x72_req_ctrl.sv | 140 ++++++++++++++
 tb/tb_ram8x72_req_ctrl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ram8x72_req_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ram8x72_req_ctrl_pkg                                         |
// | Description : Shared state encoding and geometry constants for the 8x72   |
// |               RAM request controller (two 4x72 banks).                     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package ram8x72_req_ctrl_pkg;

  typedef enum logic [1:0] {
    HOLD = 2'd0,  // one idle cycle after reset
    INIT = 2'd1,  // zero-fill both banks in parallel
    RUN  = 2'd2   // normal request traffic
  } state_e;

  localparam int WORDS       = 8;
  localparam int BANK_WORDS  = 4;
  localparam int INIT_CYCLES = 4;
  localparam int DW          = 72;

endpackage
`default_nettype wire

// File: rtl/ram_rsp_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ram_rsp_fifo                                                 |
// | Description : Synchronous response FIFO with occupancy count and a        |
// |               registered head output that holds its last value when empty. |
// | Ports       : clk, rst_n         - clock, async active-low reset           |
// |               push, push_data    - write side (never pushed while full)    |
// |               pop_ready          - consumer takes head when valid          |
// |               valid, rdata       - head entry                              |
// |               count              - current number of entries               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module ram_rsp_fifo #(
  parameter int DW    = 72,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [DW-1:0]              push_data,
  input  logic                       pop_ready,
  output logic                       valid,
  output logic [DW-1:0]              rdata,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_ONE = {{AW{1'b0}}, 1'b1};

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d, rd_ptr_nxt;
  logic [AW:0]   count_q, count_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          pop;

  assign valid = (count_q != '0);
  assign pop   = valid & pop_ready;
  assign rdata = rdata_q;
  assign count = count_q;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    rdata_d    = rdata_q;
    rd_ptr_nxt = rd_ptr_q + 1'b1;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_nxt;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
    // The head register is refreshed only when the head entry changes:
    // either the next stored entry moves up, or a push lands in a FIFO that
    // is (or is about to be) empty. Otherwise it keeps its last value.
    if (pop && (count_q > CNT_ONE)) begin
      rdata_d = mem_q[rd_ptr_nxt];
    end else if (push && ((count_q == '0) || pop)) begin
      rdata_d = push_data;
    end
  end

  // Storage needs no reset; occupancy tracking makes stale entries invisible.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rdata_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      rdata_q  <= rdata_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ram8x72_req_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ram8x72_req_ctrl                                             |
// | Description : Request-side controller for an 8x72 RAM built from two 4x72 |
// |               banks. Zero-fills the banks after reset, then decodes        |
// |               valid/ready requests into bank strobes and queues 1-cycle    |
// |               latency read data into a response FIFO.                      |
// | Ports       : req_*        - request channel (addr[2] = bank)              |
// |               rsp_*        - response channel with backpressure           |
// |               init_done    - zero-fill complete                            |
// |               bank*_en_n, bank_wr_n, bank_add, bank_wdata - bank strobes   |
// |               bank*_rdata  - registered bank read data                     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module ram8x72_req_ctrl #(
  parameter int RSP_DEPTH = 4,
  parameter int DW        = 72
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [2:0]    req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_rdata,
  output logic          init_done,
  output logic          bank0_en_n,
  output logic          bank1_en_n,
  output logic          bank_wr_n,
  output logic [1:0]    bank_add,
  output logic [DW-1:0] bank_wdata,
  input  logic [DW-1:0] bank0_rdata,
  input  logic [DW-1:0] bank1_rdata
);

  import ram8x72_req_ctrl_pkg::*;

  localparam int BANK_BIT = $clog2(WORDS) - 1;
  localparam int ICW      = $clog2(BANK_WORDS);
  localparam logic [ICW-1:0] INIT_LAST = ICW'(INIT_CYCLES - 1);
  localparam int CW       = $clog2(RSP_DEPTH) + 1;

  state_e          state_q, state_d;
  logic [ICW-1:0]  init_cnt_q, init_cnt_d;
  logic            init_done_q, init_done_d;
  logic            rd_pend_q, rd_pend_d;
  logic            rd_bank_q, rd_bank_d;
  logic [CW-1:0]   fifo_count;
  logic [CW:0]     occupancy;
  logic            fire;
  logic            rd_fire;

  // Every in-flight read already owns a FIFO slot, so the push one cycle
  // later can never find the FIFO full. Only registered terms feed this.
  assign occupancy = {1'b0, fifo_count} + {{CW{1'b0}}, rd_pend_q};
  assign req_ready = (state_q == RUN) && (occupancy < (CW+1)'(RSP_DEPTH));
  assign fire      = req_valid & req_ready;
  assign rd_fire   = fire & ~req_we;
  assign init_done = init_done_q;

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    case (state_q)
      HOLD: state_d = INIT;
      INIT: begin
        init_cnt_d = init_cnt_q + 1'b1;
        if (init_cnt_q == INIT_LAST) state_d = RUN;
      end
      RUN:     state_d = RUN;
      default: state_d = HOLD;
    endcase
    init_done_d = (state_d == RUN);
    rd_pend_d   = rd_fire;
    rd_bank_d   = rd_fire ? req_addr[BANK_BIT] : rd_bank_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= HOLD;
      init_cnt_q  <= '0;
      init_done_q <= 1'b0;
      rd_pend_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      init_done_q <= init_done_d;
      rd_pend_q   <= rd_pend_d;
      rd_bank_q   <= rd_bank_d;
    end
  end

  // Bank strobes. Enables are gated by fire so an undefined address with
  // req_valid low cannot reach the enables.
  always_comb begin
    bank0_en_n = 1'b1;
    bank1_en_n = 1'b1;
    bank_wr_n  = 1'b1;
    bank_add   = '0;
    bank_wdata = '0;
    case (state_q)
      INIT: begin
        bank0_en_n = 1'b0;
        bank1_en_n = 1'b0;
        bank_wr_n  = 1'b0;
        bank_add   = init_cnt_q;
      end
      RUN: begin
        bank_add   = req_addr[BANK_BIT-1:0];
        bank_wdata = req_wdata;
        if (fire) begin
          bank_wr_n  = ~req_we;
          bank0_en_n = req_addr[BANK_BIT];
          bank1_en_n = ~req_addr[BANK_BIT];
        end
      end
      default: ;
    endcase
  end

  ram_rsp_fifo #(
    .DW    (DW),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (rd_pend_q),
    .push_data (rd_bank_q ? bank1_rdata : bank0_rdata),
    .pop_ready (rsp_ready),
    .valid     (rsp_valid),
    .rdata     (rsp_rdata),
    .count     (fifo_count)
  );

endmodule
`default_nettype wire

// File: tb/tb_ram8x72_req_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_ram8x72_req_ctrl                                          |
// | Description : Directed self-checking bench for ram8x72_req_ctrl with a    |
// |               behavioural model of the two 4x72 banks.                     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_ram8x72_req_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_addr;
  logic [71:0] req_wdata;
  logic        rsp_valid, rsp_ready;
  logic [71:0] rsp_rdata;
  logic        init_done;
  logic        bank0_en_n, bank1_en_n, bank_wr_n;
  logic [1:0]  bank_add;
  logic [71:0] bank_wdata;
  logic [71:0] bank0_rdata, bank1_rdata;

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;
  int last_wait;
  logic [71:0] got_q[$];
  int          got_cyc[$];

  localparam logic [71:0] D5 = 72'hA5A5_0000_0000_0000_01;

  always #5 clk = ~clk;

  ram8x72_req_ctrl #(.RSP_DEPTH(4), .DW(72)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .init_done(init_done),
    .bank0_en_n(bank0_en_n), .bank1_en_n(bank1_en_n), .bank_wr_n(bank_wr_n),
    .bank_add(bank_add), .bank_wdata(bank_wdata),
    .bank0_rdata(bank0_rdata), .bank1_rdata(bank1_rdata)
  );

  // Two 4x72 banks: write or registered read when enabled.
  logic [71:0] b0_mem [4];
  logic [71:0] b1_mem [4];
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!bank0_en_n) begin
      if (!bank_wr_n) b0_mem[bank_add] <= bank_wdata;
      else            bank0_rdata      <= b0_mem[bank_add];
    end
    if (!bank1_en_n) begin
      if (!bank_wr_n) b1_mem[bank_add] <= bank_wdata;
      else            bank1_rdata      <= b1_mem[bank_add];
    end
  end

  // Response collector: an entry is consumed at the edge following this sample.
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      got_q.push_back(rsp_rdata);
      got_cyc.push_back(cyc);
    end
  end

  task automatic check_eq(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Hold a request until it fires; returns with the next cycle just started.
  task automatic issue(input logic we, input logic [2:0] addr, input logic [71:0] data);
    logic fired;
    fired     = 1'b0;
    last_wait = 0;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = data;
    for (int k = 0; k < 40 && !fired; k++) begin
      @(negedge clk);
      fired = req_ready;
      last_wait++;
      @(posedge clk);
      #1;
    end
    if (!fired) check_eq("issue_timeout", 72'd0, 72'd1);
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int n);
    for (int k = 0; k < 40 && got_q.size() < n; k++) @(negedge clk);
    check_eq("rsp_count", 72'(got_q.size()), 72'(n));
  endtask

  // Release reset at posedge+1 and walk HOLD, four INIT cycles and RUN entry.
  task automatic release_and_init(input string tag);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_eq({tag, "_hold_en"}, {70'd0, bank0_en_n, bank1_en_n}, 72'd3);
    check_eq({tag, "_hold_done"}, 72'(init_done), 72'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq({tag, "_init_strobes"}, {69'd0, bank0_en_n, bank1_en_n, bank_wr_n}, 72'd0);
      check_eq({tag, "_init_add"}, 72'(bank_add), 72'(i));
      check_eq({tag, "_init_wdata"}, bank_wdata, 72'd0);
      check_eq({tag, "_init_ready"}, 72'(req_ready), 72'd0);
    end
    @(negedge clk);
    check_eq({tag, "_init_done"}, 72'(init_done), 72'd1);
    check_eq({tag, "_run_ready"}, 72'(req_ready), 72'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = 3'd0;
    req_wdata = 72'd0; rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("rst_rsp_valid", 72'(rsp_valid), 72'd0);
    check_eq("rst_rsp_rdata", rsp_rdata, 72'd0);
    check_eq("rst_init_done", 72'(init_done), 72'd0);
    check_eq("rst_req_ready", 72'(req_ready), 72'd0);
    check_eq("rst_strobes", {69'd0, bank0_en_n, bank1_en_n, bank_wr_n}, 72'd7);

    release_and_init("first");

    // Every word reads back zero after the fill.
    for (int a = 0; a < 8; a++) issue(1'b0, 3'(a), 72'd0);
    wait_rsp(8);
    for (int i = 0; i < 8 && i < got_q.size(); i++) check_eq("zero_fill", got_q[i], 72'd0);
    got_q.delete(); got_cyc.delete();

    // Write then read word 5 (bank 1, word 1) with strobe and latency checks.
    req_valid = 1'b1; req_we = 1'b1; req_addr = 3'd5; req_wdata = D5;
    @(negedge clk);
    check_eq("wr5_strobes", {68'd0, bank0_en_n, bank1_en_n, bank_wr_n, req_ready}, 72'b1001);
    check_eq("wr5_add", 72'(bank_add), 72'd1);
    check_eq("wr5_wdata", bank_wdata, D5);
    @(posedge clk); #1;
    req_we = 1'b0; req_wdata = 72'd0;
    @(negedge clk);
    check_eq("rd5_strobes", {68'd0, bank0_en_n, bank1_en_n, bank_wr_n, req_ready}, 72'b1011);
    check_eq("rd5_add", 72'(bank_add), 72'd1);
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk);
    check_eq("rd5_n1_valid", 72'(rsp_valid), 72'd0);
    @(negedge clk);
    check_eq("rd5_n2_valid", 72'(rsp_valid), 72'd1);
    check_eq("rd5_n2_data", rsp_rdata, D5);
    @(posedge clk); #1;
    got_q.delete(); got_cyc.delete();

    // Back-to-back reads alternating banks: one fire per cycle, in order.
    issue(1'b1, 3'd0, 72'd1);
    issue(1'b1, 3'd4, 72'd2);
    for (int i = 0; i < 4; i++) begin
      issue(1'b0, (i % 2 == 0) ? 3'd0 : 3'd4, 72'd0);
      check_eq("b2b_one_cycle", 72'(last_wait), 72'd1);
    end
    wait_rsp(4);
    if (got_q.size() >= 4) begin
      for (int i = 0; i < 4; i++)
        check_eq("b2b_data", got_q[i], (i % 2 == 0) ? 72'd1 : 72'd2);
      for (int i = 1; i < 4; i++)
        check_eq("b2b_spacing", 72'(got_cyc[i] - got_cyc[i-1]), 72'd1);
    end
    got_q.delete(); got_cyc.delete();

    // Backpressure: four reads fill the reservation budget.
    issue(1'b1, 3'd1, 72'd11);
    issue(1'b1, 3'd2, 72'd22);
    issue(1'b1, 3'd6, 72'd66);
    issue(1'b1, 3'd7, 72'd77);
    rsp_ready = 1'b0;
    issue(1'b0, 3'd1, 72'd0);
    issue(1'b0, 3'd2, 72'd0);
    issue(1'b0, 3'd6, 72'd0);
    issue(1'b0, 3'd7, 72'd0);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 3'd0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("bp_ready_low", 72'(req_ready), 72'd0);
      check_eq("bp_no_enable", {70'd0, bank0_en_n, bank1_en_n}, 72'd3);
    end
    check_eq("bp_head", rsp_rdata, 72'd11);
    check_eq("bp_valid", 72'(rsp_valid), 72'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    wait_rsp(4);
    if (got_q.size() >= 4) begin
      check_eq("bp_drain0", got_q[0], 72'd11);
      check_eq("bp_drain1", got_q[1], 72'd22);
      check_eq("bp_drain2", got_q[2], 72'd66);
      check_eq("bp_drain3", got_q[3], 72'd77);
    end
    @(negedge clk);
    check_eq("bp_ready_back", 72'(req_ready), 72'd1);
    check_eq("bp_exactly4", 72'(got_q.size()), 72'd4);
    @(posedge clk); #1;
    got_q.delete(); got_cyc.delete();

    // Read-after-write to the same word in consecutive cycles.
    issue(1'b1, 3'd3, 72'hFF);
    issue(1'b0, 3'd3, 72'd0);
    wait_rsp(1);
    if (got_q.size() >= 1) check_eq("raw_data", got_q[0], 72'hFF);
    got_q.delete(); got_cyc.delete();

    // Reset with a read pending and two entries buffered.
    rsp_ready = 1'b0;
    issue(1'b0, 3'd6, 72'd0);
    issue(1'b0, 3'd7, 72'd0);
    issue(1'b0, 3'd1, 72'd0);
    @(negedge clk);
    check_eq("pre_rst_valid", 72'(rsp_valid), 72'd1);
    check_eq("pre_rst_head", rsp_rdata, 72'd66);
    #2 rst_n = 1'b0;
    #1;
    check_eq("async_rst_valid", 72'(rsp_valid), 72'd0);
    check_eq("async_rst_ready", 72'(req_ready), 72'd0);
    check_eq("async_rst_done", 72'(init_done), 72'd0);
    check_eq("async_rst_rdata", rsp_rdata, 72'd0);
    rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    release_and_init("reinit");
    check_eq("reinit_no_stale", 72'(got_q.size()), 72'd0);
    issue(1'b0, 3'd6, 72'd0);
    issue(1'b0, 3'd7, 72'd0);
    issue(1'b0, 3'd3, 72'd0);
    issue(1'b0, 3'd5, 72'd0);
    wait_rsp(4);
    for (int i = 0; i < 4 && i < got_q.size(); i++) check_eq("reinit_zero", got_q[i], 72'd0);

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
